param_instruction_memory: RTL and testbench
===========================================

PARAM_INSTRUCTION_MEMORY -- requirements
Module: param_instruction_memory

Interface
REQ-001 Parameter DATA_WIDTH, 16, instruction word width in bits; a multiple of 8 and at least 16.
REQ-002 Parameter ADDR_WIDTH, 16, byte-address width.
REQ-003 Parameter DEPTH, 256, number of words stored.
REQ-004 Derived constant WORD_BYTES = DATA_WIDTH/8, address increment per word.
REQ-005 CLK  in  1  single clock; all state changes on the rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 WRITE_ENABLE  in  1  write DATA_IN to the word at ADDRESS.
REQ-008 READ_ENABLE  in  1  fetch request.
REQ-009 FETCH_MODE  in  1  0: fetch from ADDRESS; 1: fetch from the internal PC.
REQ-010 PC_LOAD  in  1  load the PC from ADDRESS.
REQ-011 ADDRESS  in  ADDR_WIDTH  byte address.
REQ-012 DATA_IN  in  DATA_WIDTH  write data.
REQ-013 DATA_OUT  out  DATA_WIDTH  registered fetch data.
REQ-014 DATA_VALID  out  1  DATA_OUT carries a good fetch this cycle.
REQ-015 ADDR_ERR  out  1  the last fetch address was misaligned or out of range.
REQ-016 PC_OUT  out  ADDR_WIDTH  current PC.
REQ-017 PARITY_ERR  out  1  parity mismatch on the last fetch; see Configuration.

Function
REQ-018 Fetch address = PC when FETCH_MODE=1, else ADDRESS; word index = fetch address / WORD_BYTES.
REQ-019 An address is bad when it is misaligned (fetch address mod WORD_BYTES != 0) or its word index >= DEPTH.
REQ-020 Read latency is 1 cycle: a READ_ENABLE sample with a good address sets DATA_OUT = mem[index], DATA_VALID=1 and ADDR_ERR=0 on the next edge.
REQ-021 A READ_ENABLE sample with a bad address sets DATA_VALID=0 and ADDR_ERR=1 on the next edge; DATA_OUT holds its value.
REQ-022 With READ_ENABLE=0, DATA_VALID=0 and ADDR_ERR=0 on the next edge; DATA_OUT holds its value.
REQ-023 A write always addresses memory through ADDRESS, regardless of FETCH_MODE; a write to a bad address is dropped without side effects.
REQ-024 Read and write to the same word in one cycle: the read returns the old data (read-before-write); the new data is visible from the next access.
REQ-025 PC_LOAD=1: PC <= ADDRESS on the next edge; PC_LOAD has priority over the increment.
REQ-026 FETCH_MODE=1, READ_ENABLE=1, PC_LOAD=0, good PC: PC <= PC + WORD_BYTES; a bad PC holds the PC.
REQ-027 PC arithmetic is modulo 2^ADDR_WIDTH; a PC that wraps past DEPTH*WORD_BYTES reports ADDR_ERR on the next fetch.
REQ-028 PC_LOAD together with a sequential fetch: the fetch uses the old PC, and the PC takes ADDRESS.
REQ-029 PC_OUT continuously reflects the PC register.

Reset
REQ-030 RST=1 immediately forces DATA_OUT=0, DATA_VALID=0, ADDR_ERR=0, PARITY_ERR=0 and PC=0, independent of CLK.
REQ-031 Memory contents are not cleared by RST and survive reset.
REQ-032 Requests sampled while RST=1 are ignored, including writes; normal operation resumes on the first edge after release.

Configuration
REQ-033 Macro IMEM_PARITY_EN defined: each word stores an extra even-parity bit computed from DATA_IN on write.
REQ-034 With IMEM_PARITY_EN, every good fetch recomputes parity; a mismatch sets PARITY_ERR=1 in the same cycle as DATA_VALID=1, otherwise PARITY_ERR=0.
REQ-035 Without IMEM_PARITY_EN, no parity storage exists, PARITY_ERR is tied to 0, and the port list is unchanged.

Verification (DATA_WIDTH=16, ADDR_WIDTH=16, DEPTH=256)
REQ-036 After reset, write 0xABCD to 0x0004, then read 0x0004 with FETCH_MODE=0 -> next cycle DATA_OUT=0xABCD, DATA_VALID=1, ADDR_ERR=0.
REQ-037 Preload 0x0010/0x0012/0x0014; PC_LOAD with ADDRESS=0x0010; three READ_ENABLE cycles with FETCH_MODE=1 -> the three words returned in order, then PC_OUT=0x0016.
REQ-038 Read 0x0003 -> ADDR_ERR=1, DATA_VALID=0. Read 0x0200 -> ADDR_ERR=1. Write 0x5555 to 0x0200 -> no memory word changes.
REQ-039 Word 0x0020 holds 0x1111; same-cycle write 0x2222 and read 0x0020 -> DATA_OUT=0x1111; the following read returns 0x2222.
REQ-040 Assert RST mid-way through a sequential fetch -> outputs zero and PC_OUT=0x0000 before the next edge; a read of 0x0004 afterwards returns 0xABCD.
REQ-041 With IMEM_PARITY_EN, write 0x00FF, force one stored data bit inverted, read -> DATA_VALID=1, PARITY_ERR=1; without the macro PARITY_ERR stays 0.

Source files
------------

// File: rtl/param_instruction_memory_if.sv
// Request/response bundle for param_instruction_memory; clk/rst stay plain module ports.
interface param_instruction_memory_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  write_enable;
  logic                  read_enable;
  logic                  fetch_mode;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic                  parity_err;

  modport master (
    output write_enable, read_enable, fetch_mode, pc_load, address, data_in,
    input  data_out, data_valid, addr_err, pc_out, parity_err
  );

  modport slave (
    input  write_enable, read_enable, fetch_mode, pc_load, address, data_in,
    output data_out, data_valid, addr_err, pc_out, parity_err
  );
endinterface

// File: rtl/param_instruction_memory.sv
// Byte-addressed instruction memory with internal PC, 1-cycle registered fetch, address checking.
// Optional per-word even parity when IMEM_PARITY_EN is defined.
module param_instruction_memory #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input logic clk,
  input logic rst,
  param_instruction_memory_if.slave bus
);
  localparam int WORD_BYTES = DATA_WIDTH / 8;
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  addr_err_q;
  logic [ADDR_WIDTH-1:0] pc_q;

  logic [ADDR_WIDTH-1:0] rd_addr, rd_word, wr_word;
  logic                  rd_good, wr_good;
  logic [IDX_W-1:0]      rd_idx, wr_idx;

  // Fetch follows the PC in sequential mode; writes always use the bus address.
  assign rd_addr = bus.fetch_mode ? pc_q : bus.address;
  assign rd_word = rd_addr / ADDR_WIDTH'(WORD_BYTES);
  assign wr_word = bus.address / ADDR_WIDTH'(WORD_BYTES);
  assign rd_good = ((rd_addr % ADDR_WIDTH'(WORD_BYTES)) == '0) && (rd_word < ADDR_WIDTH'(DEPTH));
  assign wr_good = ((bus.address % ADDR_WIDTH'(WORD_BYTES)) == '0) && (wr_word < ADDR_WIDTH'(DEPTH));
  assign rd_idx  = rd_word[IDX_W-1:0];
  assign wr_idx  = wr_word[IDX_W-1:0];

  // Storage is not reset so program contents survive RST.
  always_ff @(posedge clk) begin
    if (!rst && bus.write_enable && wr_good)
      mem[wr_idx] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      pc_q         <= '0;
    end else begin
      data_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      if (bus.read_enable) begin
        if (rd_good) begin
          data_out_q   <= mem[rd_idx];
          data_valid_q <= 1'b1;
        end else begin
          addr_err_q   <= 1'b1;
        end
      end
      // A load wins over the increment; a fetch in the same cycle used the old PC.
      if (bus.pc_load)
        pc_q <= bus.address;
      else if (bus.fetch_mode && bus.read_enable && rd_good)
        pc_q <= pc_q + ADDR_WIDTH'(WORD_BYTES);
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];
  logic parity_err_q;

  always_ff @(posedge clk) begin
    if (!rst && bus.write_enable && wr_good)
      par_mem[wr_idx] <= ^bus.data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      parity_err_q <= 1'b0;
    else
      parity_err_q <= bus.read_enable && rd_good && (^{mem[rd_idx], par_mem[rd_idx]});
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.pc_out     = pc_q;
endmodule

// File: tb/tb_param_instruction_memory.sv
// Directed table-driven bench for param_instruction_memory (16-bit words, 256 deep).
module tb_param_instruction_memory;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  param_instruction_memory_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

  param_instruction_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we, re, fm, pl;
    logic [15:0] addr, din;
    logic [15:0] dout;
    logic        vld, err;
    logic [15:0] pc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic we, logic re, logic fm, logic pl, logic [15:0] addr,
                              logic [15:0] din, logic [15:0] dout, logic vld, logic err,
                              logic [15:0] pc);
    vec_t v;
    v.we = we; v.re = re; v.fm = fm; v.pl = pl; v.addr = addr; v.din = din;
    v.dout = dout; v.vld = vld; v.err = err; v.pc = pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic fm, input logic pl,
                       input logic [15:0] addr, input logic [15:0] din);
    bus.write_enable = we; bus.read_enable = re; bus.fetch_mode = fm;
    bus.pc_load = pl; bus.address = addr; bus.data_in = din;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [15:0] dout, input logic vld,
                            input logic err, input logic [15:0] pc, input logic perr);
    check({tag, ".data_out"},   32'(bus.data_out),   32'(dout));
    check({tag, ".data_valid"}, 32'(bus.data_valid), 32'(vld));
    check({tag, ".addr_err"},   32'(bus.addr_err),   32'(err));
    check({tag, ".pc_out"},     32'(bus.pc_out),     32'(pc));
    check({tag, ".parity_err"}, 32'(bus.parity_err), 32'(perr));
  endtask

  initial begin
    //     we re fm pl addr      din        dout     vld err pc
    vt.push_back(mk(1, 0, 0, 0, 16'h0004, 16'hABCD, 16'h0000, 0, 0, 16'h0000));
    vt.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0F0F, 16'h0000, 0, 0, 16'h0000));
    vt.push_back(mk(0, 1, 0, 0, 16'h0004, 16'h0000, 16'hABCD, 1, 0, 16'h0000));
    vt.push_back(mk(1, 0, 0, 0, 16'h0010, 16'h1234, 16'hABCD, 0, 0, 16'h0000));
    vt.push_back(mk(1, 0, 0, 0, 16'h0012, 16'h5678, 16'hABCD, 0, 0, 16'h0000));
    vt.push_back(mk(1, 0, 0, 0, 16'h0014, 16'h9ABC, 16'hABCD, 0, 0, 16'h0000));
    vt.push_back(mk(0, 0, 0, 1, 16'h0010, 16'h0000, 16'hABCD, 0, 0, 16'h0010));
    vt.push_back(mk(0, 1, 1, 0, 16'h0000, 16'h0000, 16'h1234, 1, 0, 16'h0012));
    vt.push_back(mk(0, 1, 1, 0, 16'h0000, 16'h0000, 16'h5678, 1, 0, 16'h0014));
    vt.push_back(mk(0, 1, 1, 0, 16'h0000, 16'h0000, 16'h9ABC, 1, 0, 16'h0016));
    vt.push_back(mk(0, 1, 0, 0, 16'h0003, 16'h0000, 16'h9ABC, 0, 1, 16'h0016));
    vt.push_back(mk(0, 1, 0, 0, 16'h0200, 16'h0000, 16'h9ABC, 0, 1, 16'h0016));
    vt.push_back(mk(1, 0, 0, 0, 16'h0200, 16'h5555, 16'h9ABC, 0, 0, 16'h0016));
    vt.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0F0F, 1, 0, 16'h0016));
    vt.push_back(mk(1, 0, 0, 0, 16'h0020, 16'h1111, 16'h0F0F, 0, 0, 16'h0016));
    vt.push_back(mk(1, 1, 0, 0, 16'h0020, 16'h2222, 16'h1111, 1, 0, 16'h0016));
    vt.push_back(mk(0, 1, 0, 0, 16'h0020, 16'h0000, 16'h2222, 1, 0, 16'h0016));
    vt.push_back(mk(1, 0, 0, 0, 16'h0016, 16'h7777, 16'h2222, 0, 0, 16'h0016));
    vt.push_back(mk(1, 0, 0, 0, 16'h01FE, 16'hBEEF, 16'h2222, 0, 0, 16'h0016));
    vt.push_back(mk(0, 1, 1, 1, 16'h01FE, 16'h0000, 16'h7777, 1, 0, 16'h01FE));
    vt.push_back(mk(0, 1, 1, 0, 16'h0000, 16'h0000, 16'hBEEF, 1, 0, 16'h0200));
    vt.push_back(mk(0, 1, 1, 0, 16'h0000, 16'h0000, 16'hBEEF, 0, 1, 16'h0200));
    vt.push_back(mk(0, 0, 0, 1, 16'h0011, 16'h0000, 16'hBEEF, 0, 0, 16'h0011));
    vt.push_back(mk(0, 1, 1, 0, 16'h0000, 16'h0000, 16'hBEEF, 0, 1, 16'h0011));
    vt.push_back(mk(1, 0, 1, 0, 16'h0030, 16'hC0DE, 16'hBEEF, 0, 0, 16'h0011));
    vt.push_back(mk(0, 1, 0, 0, 16'h0030, 16'h0000, 16'hC0DE, 1, 0, 16'h0011));
    vt.push_back(mk(0, 1, 1, 1, 16'hFFFE, 16'h0000, 16'hC0DE, 0, 1, 16'hFFFE));
    vt.push_back(mk(0, 1, 1, 0, 16'h0000, 16'h0000, 16'hC0DE, 0, 1, 16'hFFFE));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'hC0DE, 0, 0, 16'hFFFE));

    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    rst = 1'b1;
    tick();
    tick();
    check_outs("reset", 16'h0000, 0, 0, 16'h0000, 0);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].we, vt[i].re, vt[i].fm, vt[i].pl, vt[i].addr, vt[i].din);
      tick();
      check_outs($sformatf("vec%0d", i), vt[i].dout, vt[i].vld, vt[i].err, vt[i].pc, 1'b0);
    end

    // Reset in the middle of a sequential run; a write held during reset must be dropped.
    drive(0, 0, 0, 1, 16'h0010, 16'h0000);
    tick();
    drive(0, 1, 1, 0, 16'h0000, 16'h0000);
    tick();
    check_outs("seq_pre_rst", 16'h1234, 1, 0, 16'h0012, 0);
    rst = 1'b1;
    #1;
    check_outs("async_rst", 16'h0000, 0, 0, 16'h0000, 0);
    drive(1, 1, 0, 0, 16'h0004, 16'hDEAD);
    tick();
    check_outs("in_rst", 16'h0000, 0, 0, 16'h0000, 0);
    rst = 1'b0;
    drive(0, 1, 0, 0, 16'h0004, 16'h0000);
    tick();
    check_outs("post_rst_read", 16'hABCD, 1, 0, 16'h0000, 0);

    // Parity: a good word reads clean; a corrupted one flags in the valid cycle.
    drive(1, 0, 0, 0, 16'h0040, 16'h00FF);
    tick();
    drive(0, 1, 0, 0, 16'h0040, 16'h0000);
    tick();
    check_outs("par_clean", 16'h00FF, 1, 0, 16'h0000, 0);
`ifdef IMEM_PARITY_EN
    dut.mem[32] = dut.mem[32] ^ 16'h0001;
    tick();
    check_outs("par_corrupt", 16'h00FE, 1, 0, 16'h0000, 1);
`else
    tick();
    check_outs("par_off", 16'h00FF, 1, 0, 16'h0000, 0);
`endif
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    tick();
    check_outs("idle_end", bus.data_valid ? 16'h0000 : 16'h00FF, 0, 0, 16'h0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
